// File: rtl/dmem_fill_port.sv
// dmem_fill_port: owns dmem's single write/address port. In IDLE the CPU
// access passes straight through with zero latency. On a fill request the
// block stalls the CPU and writes a constant or incrementing pattern over a
// contiguous, wrapping address range.
// Optional feature macro: DMEM_FILL_VERIFY_EN adds a VERIFY readback pass and
// the sticky fill_error output.
module dmem_fill_port #(
  parameter int Nloc  = 64,
  parameter int Dbits = 32,
  localparam int AW   = $clog2(Nloc)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_wr,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [Dbits-1:0] cpu_writedata,
  output logic             cpu_stall,
  input  logic             fill_start,
  input  logic [AW-1:0]    fill_base,
  input  logic [AW:0]      fill_len,
  input  logic [Dbits-1:0] fill_value,
  input  logic             fill_incr,
  output logic             fill_busy,
  output logic             fill_done,
`ifdef DMEM_FILL_VERIFY_EN
  output logic             fill_error,
`endif
  output logic             mem_wr,
  output logic [AW-1:0]    mem_addr,
  output logic [Dbits-1:0] mem_writedata,
  input  logic [Dbits-1:0] mem_readdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
`ifdef DMEM_FILL_VERIFY_EN
    S_VERIFY = 2'd3,
`endif
    S_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      k_q, k_d;
  logic [AW-1:0]    base_q;
  logic [AW:0]      len_q;
  logic [Dbits-1:0] value_q;
  logic             incr_q;
  logic             accept;

  logic [AW:0]      len_clamped;
  logic [AW:0]      addr_sum;
  logic [AW-1:0]    fill_addr;
  logic [Dbits-1:0] fill_word;
  logic             last_k;

`ifdef DMEM_FILL_VERIFY_EN
  logic             error_q, error_d;
  assign fill_error = error_q;
`else
  // Readback data is only consumed by the VERIFY pass.
  logic             unused_readdata;
  assign unused_readdata = ^mem_readdata;
`endif

  // Requests longer than the memory are clamped to one full pass.
  assign len_clamped = (fill_len > (AW+1)'(Nloc)) ? (AW+1)'(Nloc) : fill_len;

  // base < Nloc and k < Nloc, so a single conditional subtract gives the wrap
  // even when Nloc is not a power of two.
  assign addr_sum  = {1'b0, base_q} + k_q;
  assign fill_addr = (addr_sum >= (AW+1)'(Nloc)) ? AW'(addr_sum - (AW+1)'(Nloc))
                                                 : AW'(addr_sum);
  assign fill_word = incr_q ? (value_q + Dbits'(k_q)) : value_q;
  assign last_k    = (k_q == (len_q - (AW+1)'(1)));

  // Next-state and port mux; reset overrides the write strobe immediately.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    accept        = 1'b0;
    cpu_stall     = 1'b1;
    fill_busy     = 1'b1;
    fill_done     = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = fill_addr;
    mem_writedata = fill_word;
`ifdef DMEM_FILL_VERIFY_EN
    error_d       = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        cpu_stall     = 1'b0;
        fill_busy     = 1'b0;
        mem_wr        = cpu_wr;
        mem_addr      = cpu_addr;
        mem_writedata = cpu_writedata;
        if (fill_start) begin
          accept  = 1'b1;
          k_d     = '0;
`ifdef DMEM_FILL_VERIFY_EN
          error_d = 1'b0;
`endif
          state_d = (len_clamped == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        mem_wr = 1'b1;
        if (last_k) begin
          k_d     = '0;
`ifdef DMEM_FILL_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = S_DONE;
`endif
        end else begin
          k_d = k_q + (AW+1)'(1);
        end
      end
`ifdef DMEM_FILL_VERIFY_EN
      S_VERIFY: begin
        if (mem_readdata != fill_word) error_d = 1'b1;
        if (last_k) begin
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + (AW+1)'(1);
        end
      end
`endif
      S_DONE: begin
        fill_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) mem_wr = 1'b0;
  end

  // FSM state and word pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Fill parameters captured on the accepting edge.
  always_ff @(posedge clock) begin
    if (accept && !reset) begin
      base_q  <= fill_base;
      len_q   <= len_clamped;
      value_q <= fill_value;
      incr_q  <= fill_incr;
    end
  end

`ifdef DMEM_FILL_VERIFY_EN
  // Sticky readback mismatch flag.
  always_ff @(posedge clock) begin
    if (reset) error_q <= 1'b0;
    else       error_q <= error_d;
  end
`endif

endmodule

// File: tb/tb_dmem_fill_port.sv
// Bench for dmem_fill_port: directed cases plus random traffic, checked every
// cycle against a schedule-based model of the fill sequence.
`timescale 1ns/1ps
module tb_dmem_fill_port;
  localparam int Nloc = 64;
  localparam int AW   = 6;
`ifdef DMEM_FILL_VERIFY_EN
  localparam int VER = 1;
`else
  localparam int VER = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wr = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0] cpu_writedata = '0;
  logic        cpu_stall;
  logic        fill_start = 1'b0;
  logic [AW-1:0] fill_base = '0;
  logic [AW:0] fill_len = '0;
  logic [31:0] fill_value = '0;
  logic        fill_incr = 1'b0;
  logic        fill_busy, fill_done;
  logic        mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_writedata, mem_readdata;
`ifdef DMEM_FILL_VERIFY_EN
  logic        fill_error;
`endif

  always #5 clock = ~clock;

  dmem_fill_port #(.Nloc(Nloc), .Dbits(32)) dut (
    .clock(clock), .reset(reset),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_writedata(cpu_writedata),
    .cpu_stall(cpu_stall),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_value(fill_value), .fill_incr(fill_incr),
    .fill_busy(fill_busy), .fill_done(fill_done),
`ifdef DMEM_FILL_VERIFY_EN
    .fill_error(fill_error),
`endif
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata)
  );

  // dmem stand-in: asynchronous read, posedge write, plus a backdoor port.
  bit [31:0]     dmem [Nloc];
  logic          bd_en = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;
  assign mem_readdata = dmem[mem_addr];
  always @(posedge clock) begin
    if (mem_wr) dmem[mem_addr] <= mem_writedata;
    if (bd_en)  dmem[bd_addr]  <= bd_data;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_cnt is the cycle number since the accepting edge
  // (0 = idle). A fill of N words writes in cycles 1..N, optionally reads back
  // in N+1..2N, and ends with DONE in the last cycle m_total.
  bit [31:0] ref_mem [Nloc];
  int        m_cnt = 0, m_base = 0, m_len = 0, m_total = 0;
  bit [31:0] m_val = 0;
  bit        m_inc = 0, m_err = 0;

  function automatic int m_addr(input int i);
    return (m_base + i) % Nloc;
  endfunction
  function automatic bit [31:0] m_word(input int i);
    return m_inc ? (m_val + 32'(i)) : m_val;
  endfunction

  // Model update at each edge from the inputs of the cycle just ending.
  always @(posedge clock) begin
    if (reset) begin
      m_cnt = 0;
      m_err = 0;
    end else if (m_cnt == 0) begin
      if (cpu_wr) ref_mem[cpu_addr] = cpu_writedata;
      if (fill_start) begin
        m_base  = int'(fill_base);
        m_len   = (int'(fill_len) > Nloc) ? Nloc : int'(fill_len);
        m_val   = fill_value;
        m_inc   = fill_incr;
        m_err   = 0;
        m_total = m_len * (1 + VER) + 1;
        m_cnt   = 1;
      end
    end else begin
      if (m_cnt <= m_len) ref_mem[m_addr(m_cnt - 1)] = m_word(m_cnt - 1);
      else if (m_cnt < m_total && ref_mem[m_addr(m_cnt - 1 - m_len)] != m_word(m_cnt - 1 - m_len))
        m_err = 1;
      m_cnt++;
      if (m_cnt > m_total) m_cnt = 0;
    end
    if (bd_en) ref_mem[bd_addr] = bd_data;
  end

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clock) begin
    if (reset) begin
      chk("wr_during_reset", 32'(mem_wr), 32'd0);
    end else if (m_cnt == 0) begin
      chk("idle_busy",  32'(fill_busy), 32'd0);
      chk("idle_stall", 32'(cpu_stall), 32'd0);
      chk("idle_done",  32'(fill_done), 32'd0);
      chk("pass_wr",    32'(mem_wr),   32'(cpu_wr));
      chk("pass_addr",  32'(mem_addr), 32'(cpu_addr));
      chk("pass_data",  mem_writedata, cpu_writedata);
    end else begin
      chk("busy",  32'(fill_busy), 32'd1);
      chk("stall", 32'(cpu_stall), 32'd1);
      chk("done",  32'(fill_done), 32'(m_cnt == m_total));
      chk("fill_wr", 32'(mem_wr), 32'(m_cnt <= m_len));
      if (m_cnt <= m_len) begin
        chk("fill_addr", 32'(mem_addr), 32'(m_addr(m_cnt - 1)));
        chk("fill_data", mem_writedata, m_word(m_cnt - 1));
      end else if (m_cnt < m_total) begin
        chk("verify_addr", 32'(mem_addr), 32'(m_addr(m_cnt - 1 - m_len)));
      end
      if (fill_done)
        $display("fill done: base=%0d len=%0d value=%h incr=%0d cycle=%0d",
                 m_base, m_len, m_val, m_inc, m_cnt);
    end
`ifdef DMEM_FILL_VERIFY_EN
    if (!reset) chk("fill_error", 32'(fill_error), 32'(m_err));
`endif
  end

  // Entered just after a posedge; returns just after the first IDLE edge.
  task automatic do_fill(input int b, input int l, input logic [31:0] v, input bit inc,
                         output int done_cyc, output int nwr);
    fill_start = 1'b1; fill_base = AW'(b); fill_len = (AW+1)'(l);
    fill_value = v; fill_incr = inc; cpu_wr = 1'b0;
    @(posedge clock); #1;
    fill_start = 1'b0;
    done_cyc = -1; nwr = 0;
    for (int c = 1; c < 400 && done_cyc < 0; c++) begin
      @(negedge clock);
      if (mem_wr) nwr++;
      if (fill_done) done_cyc = c;
      @(posedge clock); #1;
    end
    if (done_cyc < 0) begin
      total++; bad++;
      $display("FAIL fill_timeout: got=no fill_done want=fill_done base=%0d len=%0d", b, l);
    end
  endtask

  task automatic cpu_write(input int a, input logic [31:0] d);
    cpu_wr = 1'b1; cpu_addr = AW'(a); cpu_writedata = d;
    @(posedge clock); #1;
    cpu_wr = 1'b0;
  endtask

  int dc, nw, ndone;

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_busy",  32'(fill_busy), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_done",  32'(fill_done), 32'd0);
`ifdef DMEM_FILL_VERIFY_EN
    chk("rst_error", 32'(fill_error), 32'd0);
`endif
    @(posedge clock); #1;

    // Pass-through write then read.
    cpu_wr = 1'b1; cpu_addr = 6'd5; cpu_writedata = 32'hDEADBEEF;
    @(negedge clock);
    chk("pt_wr_same_cycle", 32'(mem_wr), 32'd1);
    @(posedge clock); #1;
    cpu_wr = 1'b0;
    @(negedge clock);
    chk("pt_readback", mem_readdata, 32'hDEADBEEF);
    @(posedge clock); #1;

    // Constant fill base=10 len=4 with guarded neighbours.
    cpu_write(9, 32'h99);
    cpu_write(14, 32'h1414);
    for (int a = 10; a < 14; a++) cpu_write(a, 32'hAAAA);
    do_fill(10, 4, 32'h0, 1'b0, dc, nw);
    chk("const_done_cycle", 32'(dc), 32'(4 * (1 + VER) + 1));
    chk("const_writes", 32'(nw), 32'd4);
    for (int a = 10; a < 14; a++) chk("const_word", dmem[a], 32'h0);
    chk("const_below", dmem[9], 32'h99);
    chk("const_above", dmem[14], 32'h1414);

    // Wrap with incrementing pattern through 2^32.
    do_fill(62, 4, 32'hFFFFFFFE, 1'b1, dc, nw);
    chk("wrap_62", dmem[62], 32'hFFFFFFFE);
    chk("wrap_63", dmem[63], 32'hFFFFFFFF);
    chk("wrap_0",  dmem[0],  32'h0);
    chk("wrap_1",  dmem[1],  32'h1);

    // Zero length: DONE in cycle 1, no writes.
    do_fill(3, 0, 32'h7, 1'b0, dc, nw);
    chk("len0_done_cycle", 32'(dc), 32'd1);
    chk("len0_writes", 32'(nw), 32'd0);

    // Start re-asserted during FILL, then reset in cycle 3 of a len=8 fill.
    fill_start = 1'b1; fill_base = 6'd30; fill_len = 7'd8; fill_value = 32'h55; fill_incr = 1'b0;
    @(posedge clock); #1;
    fill_start = 1'b0; nw = 0; ndone = 0;
    @(negedge clock); if (mem_wr) nw++;
    @(posedge clock); #1;
    fill_start = 1'b1; fill_base = 6'd40; fill_len = 7'd2;
    @(negedge clock); if (mem_wr) nw++;
    @(posedge clock); #1;
    fill_start = 1'b0; reset = 1'b1;
    @(negedge clock); if (mem_wr) nw++;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("after_reset_busy", 32'(fill_busy), 32'd0);
    for (int c = 0; c < 12; c++) begin
      @(posedge clock); #1;
      @(negedge clock); if (fill_done) ndone++;
    end
    @(posedge clock); #1;
    chk("reset_writes", 32'(nw), 32'd2);
    chk("reset_no_done", 32'(ndone), 32'd0);
    chk("reset_w30", dmem[30], 32'h55);
    chk("reset_w31", dmem[31], 32'h55);
    chk("reset_w32", dmem[32], 32'h0);
    chk("ignored_start_w40", dmem[40], 32'h0);

    // Full-memory fill, then an over-length request clamped to Nloc.
    do_fill(7, 64, 32'd100, 1'b1, dc, nw);
    chk("full_writes", 32'(nw), 32'd64);
    chk("full_done_cycle", 32'(dc), 32'(64 * (1 + VER) + 1));
    for (int i = 0; i < 64; i++) chk("full_word", dmem[(7 + i) % 64], 32'(100 + i));
    do_fill(0, 100, 32'h77, 1'b0, dc, nw);
    chk("clamp_writes", 32'(nw), 32'd64);

`ifdef DMEM_FILL_VERIFY_EN
    // Backdoor corruption between FILL and VERIFY must raise fill_error.
    fill_start = 1'b1; fill_base = 6'd10; fill_len = 7'd4; fill_value = 32'h0; fill_incr = 1'b0;
    @(posedge clock); #1;
    fill_start = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    bd_en = 1'b1; bd_addr = 6'd12; bd_data = 32'h1;
    @(posedge clock); #1;
    bd_en = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40 && ndone == 0; c++) begin
      @(negedge clock); if (fill_done) ndone = 1;
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("verify_error_set", 32'(fill_error), 32'd1);
    @(posedge clock); #1;
    do_fill(20, 1, 32'h3, 1'b0, dc, nw);
    @(negedge clock);
    chk("verify_error_cleared", 32'(fill_error), 32'd0);
    @(posedge clock); #1;
`endif

    // Random traffic with fills, stray starts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      cpu_wr        = 1'($urandom_range(0, 1));
      cpu_addr      = AW'($urandom);
      cpu_writedata = $urandom;
      fill_start    = ($urandom_range(0, 9) == 0);
      fill_base     = AW'($urandom);
      case ($urandom_range(0, 5))
        0:       fill_len = 7'd0;
        1:       fill_len = 7'd64;
        2:       fill_len = 7'($urandom_range(65, 127));
        default: fill_len = 7'($urandom_range(1, 12));
      endcase
      fill_value    = $urandom;
      fill_incr     = 1'($urandom_range(0, 1));
      reset         = ($urandom_range(0, 199) == 0);
      @(posedge clock); #1;
    end
    reset = 1'b0; fill_start = 1'b0; cpu_wr = 1'b0;
    repeat (200) @(posedge clock);
    #1;
    for (int a = 0; a < Nloc; a++) chk("final_mem", dmem[a], ref_mem[a]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_fill_port.md
# dmem_fill_port

Front-end stage in the data path directly upstream of `dmem`: owns `dmem`'s single write/address port and feeds it either the CPU's accesses or a hardware fill sequence. On request it clears or patterns a contiguous address range, e.g. resetting the maze grid or screen words before generation, while stalling the CPU. When idle, CPU accesses pass through unchanged and with zero latency.

## Interface
- `Nloc`, 64, number of `dmem` locations; `AW = $clog2(Nloc)`
- `Dbits`, 32, data word width
- `clock`  in  1  system clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `cpu_wr`  in  1  CPU write enable
- `cpu_addr`  in  AW  CPU address
- `cpu_writedata`  in  Dbits  CPU write data
- `cpu_stall`  out  1  CPU must hold its access; high whenever the state is not IDLE
- `fill_start`  in  1  fill request, sampled in IDLE only
- `fill_base`  in  AW  first fill address, latched on accept
- `fill_len`  in  AW+1  number of words, 0..Nloc, latched on accept
- `fill_value`  in  Dbits  pattern seed, latched on accept
- `fill_incr`  in  1  pattern mode: 1 = incrementing, 0 = constant; latched on accept
- `fill_busy`  out  1  fill engine active
- `fill_done`  out  1  one-cycle completion pulse
- `fill_error`  out  1  sticky readback mismatch; only when `DMEM_FILL_VERIFY_EN` is defined
- `mem_wr`  out  1  to `dmem` `wr`
- `mem_addr`  out  AW  to `dmem` `cpu_addr`
- `mem_writedata`  out  Dbits  to `dmem` `cpu_writedata`
- `mem_readdata`  in  Dbits  from `dmem` `dmem_readdata`, asynchronous read

## Operation
- States: IDLE, FILL, VERIFY (present only with the macro), DONE.
- IDLE: `mem_wr`, `mem_addr` and `mem_writedata` are combinational copies of the CPU inputs. `cpu_stall`, `fill_busy` and `fill_done` are 0.
- IDLE with `fill_start` = 1:
  - Latch `fill_base`, `fill_len`, `fill_value` and `fill_incr`.
  - Clear the pointer `k` to 0 and clear `fill_error`.
  - If `fill_len` = 0, go to DONE. Otherwise go to FILL.
  - The CPU access in the accepting cycle still passes through.
- FILL:
  - `mem_wr` = 1.
  - `mem_addr` = (base + k) mod Nloc. Addresses wrap past Nloc-1 to 0.
  - `mem_writedata` = value + k (mod 2^Dbits) if `fill_incr` = 1, else value.
  - `k` increments each cycle.
  - After the write with k = len-1, go to VERIFY if present, else DONE.
- VERIFY:
  - `mem_wr` = 0. `mem_addr` and the expected word follow the same formulas, with `k` restarted at 0.
  - Compare `mem_readdata` against the expected word every cycle. Any mismatch sets `fill_error`.
  - After k = len-1, go to DONE.
- DONE: `fill_done` = 1 and `fill_busy` = 1 for one cycle, then go to IDLE.
- In any non-IDLE state:
  - `fill_busy` = 1 and `cpu_stall` = 1.
  - CPU inputs are ignored. `cpu_wr` is never forwarded.
  - `fill_start` is ignored and is not queued.
- `fill_error` holds its value until the next accepted start or reset.
- `fill_len` > Nloc is clamped to Nloc.
- Reset, including mid-fill:
  - Next state is IDLE. `k` = 0.
  - `fill_busy`, `fill_done` and `fill_error` are 0.
  - `mem_wr` is forced to 0 while `reset` is high.
  - No further fill writes occur. Words already written stay written.

## Timing
- Pass-through latency is 0 cycles. `mem_*` are combinational from the `cpu_*` inputs in IDLE.
- For a start accepted at posedge 0 with len = N ≥ 1 and no verify:
  - FILL occupies cycles 1..N. The write for k=i commits at posedge i+1.
  - DONE is cycle N+1. IDLE resumes at cycle N+2.
- With verify, VERIFY occupies cycles N+1..2N, DONE is cycle 2N+1, and IDLE resumes at cycle 2N+2.
- For len = 0, DONE is cycle 1 with no writes. `fill_busy` is high for 1 cycle.
- `cpu_stall` rises in cycle 1 and falls at IDLE re-entry. The CPU access presented in the first IDLE cycle is forwarded.
- All FSM state, `k` and the latched parameters are registered. `mem_*` in FILL/VERIFY are decoded from registers.

## Configuration
- `DMEM_FILL_VERIFY_EN` defined:
  - The VERIFY pass is compiled in and the `fill_error` port exists.
  - A fill occupies 2N+2 cycles from the accept edge.
- `DMEM_FILL_VERIFY_EN` undefined:
  - No VERIFY state, no comparator and no `fill_error` port.
  - FILL goes straight to DONE, and a fill occupies N+2 cycles.

## Test plan
- Pass-through: in IDLE, a CPU write of 0xDEADBEEF to addr 5 then a read of addr 5 -> `mem_wr` tracks `cpu_wr` in the same cycle, and `mem_readdata` = 0xDEADBEEF.
- Constant fill: base=10, len=4, value=0, incr=0 -> addresses 10..13 read 0, addr 9 and addr 14 are unchanged, `fill_done` pulses in cycle 5, and `cpu_stall` is high in cycles 1–5.
- Wrap and increment: Nloc=64, base=62, len=4, value=0xFFFFFFFE, incr=1 -> mem[62]=0xFFFFFFFE, mem[63]=0xFFFFFFFF, mem[0]=0, mem[1]=1.
- Edge lengths:
  - len=0 -> no `mem_wr` pulses, and `fill_done` in cycle 1.
  - len=64 -> all 64 words written once.
- Busy and reset: `fill_start` re-asserted during FILL -> ignored. `reset` asserted at cycle 3 of a len=8 fill -> `mem_wr`=0 that cycle, IDLE next, only 2 words written, and no `fill_done`.
- Verify (macro on): a CPU-side force of mem[12]=1 between FILL and VERIFY, via a bench backdoor write, for base=10, len=4, value=0 -> `fill_error`=1 after VERIFY, and it clears on the next start.
